bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

Bit-serial WIDTH-bit adder built around a single `fulladder` cell: operands are captured on a start handshake and shifted LSB-first through the cell, one bit per clock. A carry flip-flop closes the loop between bits. The block sits upstream of the full-adder cell, sequencing its a/b/cin inputs, and downstream of it, collecting its sum/cout outputs into a registered result. It trades latency for area in datapaths that need a multi-bit add from one adder cell.

## Interface

- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepting edge only.
- b_in  input  WIDTH  operand B; captured on the accepting edge only.
- cin  input  1  carry-in; captured on the accepting edge only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; high in DONE.
- sum_out  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

## Operation

- The adder core is one `fulladder` instance with port order (sum, cout, a, b, cin). It is driven by a_sr[0], b_sr[0] and carry_q.
- Internal state:
  - a_sr and b_sr: WIDTH-bit right-shift registers.
  - s_sr: WIDTH-bit result shift register. Each new sum bit enters at the MSB and the register shifts right.
  - carry_q: 1-bit carry flip-flop.
  - bit_cnt: counter, $clog2(WIDTH) bits.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1. On that edge: a_sr<=a_in, b_sr<=b_in, carry_q<=cin, bit_cnt<=0.
  - RUN, every edge:
    - s_sr <= {fa_sum, s_sr[WIDTH-1:1]}.
    - carry_q <= fa_cout.
    - a_sr and b_sr shift right by 1.
    - bit_cnt increments.
  - RUN -> DONE on the edge where bit_cnt==WIDTH-1. On that edge sum_out <= {fa_sum, s_sr[WIDTH-1:1]} and cout <= fa_cout.
  - DONE -> IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. No queuing: a request is lost unless start is held high or re-asserted in IDLE.
- sum_out and cout hold their value from the last completed operation until the next DONE entry. They do not change during RUN.
- Arithmetic is unsigned; overflow appears only as cout. No signed or overflow flag.
- Reset (any state, including mid-RUN):
  - Next state is IDLE.
  - busy=0, done=0, sum_out=0, cout=0.
  - Shift registers, carry_q and bit_cnt are cleared.
  - An in-flight operation is discarded.
- rst and start high on the same edge: rst wins and the request is not accepted.

## Timing

- Edge E0: start accepted in IDLE.
- Edges E1..E_WIDTH: RUN, one bit per edge. busy=1 from after E0 through E_WIDTH.
- After E_WIDTH: state DONE, done=1, busy=0, and sum_out/cout are valid in the same cycle done is high.
- After E_WIDTH+1: state IDLE, done=0.
- Start-accept to done latency: WIDTH edges.
- Minimum issue interval: WIDTH+2 cycles. With start held high continuously, done pulses every WIDTH+2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

All scenarios use WIDTH=8.

- Reset: hold rst 2 cycles with start=1 -> busy=0, done=0, sum_out=0x00, cout=0, no operation accepted.
- Basic add: a_in=0x5A, b_in=0x33, cin=0, start pulse -> done exactly 8 edges after the accepting edge; sum_out=0x8D, cout=0. Operands changed to 0xFF during RUN -> result unaffected.
- Carry boundaries, each as a separate operation:
  - 0xFF+0x01, cin=0 -> sum_out=0x00, cout=1.
  - 0xFF+0xFF, cin=1 -> sum_out=0xFF, cout=1.
  - 0x00+0x00, cin=1 -> sum_out=0x01, cout=0.
- Busy rejection: start a=0x10, b=0x20; pulse start with a=0x77, b=0x77 at RUN bit 3 and again in the DONE cycle -> one done pulse only, sum_out=0x30, cout=0; sum_out stays 0x30 afterward.
- Reset mid-operation: start 0xAA+0x55, assert rst for 1 cycle at RUN bit 4 -> busy=0 next cycle, no done pulse, sum_out=0x00. Then start 0x01+0x01 -> sum_out=0x02 after 8 edges.
- Back-to-back and sweep:
  - start held high with 200 random operand triples presented at each accept -> done period 10 cycles, every result matches (a+b+cin) mod 256 and bit 8.
  - Separate WIDTH=2 build: all 32 input combinations match a reference sum.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through a single
// full-adder cell, one bit per clock, with a carry flip-flop closing the loop.

module fulladder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_sr_q,    a_sr_d;
  logic [WIDTH-1:0] b_sr_q,    b_sr_d;
  logic [WIDTH-1:0] s_sr_q,    s_sr_d;
  logic             carry_q,   carry_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             cout_q,    cout_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic fa_sum;
  logic fa_cout;

  fulladder u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q)
  );

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    s_sr_d    = s_sr_q;
    carry_d   = carry_q;
    bit_cnt_d = bit_cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          a_sr_d    = a_in;
          b_sr_d    = b_in;
          carry_d   = cin;
          bit_cnt_d = '0;
        end
      end

      RUN: begin
        s_sr_d    = {fa_sum, s_sr_q[WIDTH-1:1]};
        carry_d   = fa_cout;
        a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        // The last bit goes straight to the result register so sum_out is
        // valid in the same cycle done is high.
        if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = {fa_sum, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state and registered, keeping
  // every output a flop.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order. The datapath registers are
  // cleared on reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      s_sr_q    <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      s_sr_q    <= s_sr_d;
      carry_q   <= carry_d;
      bit_cnt_q <= bit_cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: a cycle-count model of the WIDTH=8
// instance checked every cycle, directed vectors, and a WIDTH=2 sweep.

module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum_out;
  logic         cout;

  logic         start2;
  logic [1:0]   a2, b2;
  logic         cin2;
  logic         busy2, done2;
  logic [1:0]   sum2;
  logic         cout2;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
  );

  bit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum_out(sum2), .cout(cout2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request makes the block unavailable for W+1 further
  // edges; the last of those cycles is the done cycle, when the result lands.
  int           m_left = 0;
  logic [W:0]   m_res  = '0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left  = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_valid = 1'b1;
    end else if (m_left == 0) begin
      if (start) begin
        m_res  = {1'b0, a_in} + {1'b0, b_in} + (W+1)'(cin);
        m_left = W + 1;
      end
    end else begin
      m_left--;
      if (m_left == 1) {m_cout, m_sum} = m_res;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", busy, m_left >= 2);
      check("done", done, m_left == 1);
      check("sum_out", sum_out, m_sum);
      check("cout", cout, m_cout);
    end
    if (done) done_cnt++;
  end

  // Waits (bounded) for done after the accepting edge; returns edge count.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) return;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int lat);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = '1;
    b_in  = '1;
    wait_done(lat);
  endtask

  initial begin
    int lat, n0, last, n, cyc;
    rst = 1'b1; start = 1'b1; a_in = 8'h12; b_in = 8'h34; cin = 1'b1;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

    // Reset held with start high: nothing accepted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum_out, 8'h00);
    check("rst_cout", cout, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_no_accept", busy, 1'b0);

    // Basic add with operands disturbed during RUN.
    do_op(8'h5A, 8'h33, 1'b0, lat);
    check("basic_latency", lat, 8);
    check("basic_sum", sum_out, 8'h8D);
    check("basic_cout", cout, 1'b0);
    repeat (2) @(posedge clk);

    // Carry boundaries.
    do_op(8'hFF, 8'h01, 1'b0, lat);
    check("ff_01_sum", sum_out, 8'h00);
    check("ff_01_cout", cout, 1'b1);
    repeat (2) @(posedge clk);
    do_op(8'hFF, 8'hFF, 1'b1, lat);
    check("ff_ff_sum", sum_out, 8'hFF);
    check("ff_ff_cout", cout, 1'b1);
    repeat (2) @(posedge clk);
    do_op(8'h00, 8'h00, 1'b1, lat);
    check("00_00_sum", sum_out, 8'h01);
    check("00_00_cout", cout, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Busy rejection: start pulses in RUN and in DONE are dropped.
    n0 = done_cnt;
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; a_in = 8'h77; b_in = 8'h77;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("reject_done_count", done_cnt - n0, 1);
    check("reject_sum", sum_out, 8'h30);
    check("reject_cout", cout, 1'b0);
    check("reject_idle", busy, 1'b0);

    // Reset in the middle of an operation.
    n0 = done_cnt;
    a_in = 8'hAA; b_in = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_sum", sum_out, 8'h00);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - n0, 0);
    do_op(8'h01, 8'h01, 1'b0, lat);
    check("after_rst_latency", lat, 8);
    check("after_rst_sum", sum_out, 8'h02);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back with start held high and fresh random operands each cycle.
    start = 1'b1; last = -1; n = 0; cyc = 0;
    a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
    while (n < 200 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      #1;
      a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
      if (done) begin
        if (last >= 0) check("b2b_period", cyc - last, 10);
        last = cyc;
        n++;
      end
    end
    check("b2b_count", n, 200);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // WIDTH=2 exhaustive sweep.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [2:0] ref3;
          bit got;
          ref3 = 3'(a) + 3'(b) + 3'(c);
          a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c); start2 = 1'b1;
          @(posedge clk);
          #1 start2 = 1'b0;
          got = 1'b0;
          for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk);
            #1;
            if (done2) got = 1'b1;
          end
          check("w2_done", done2, 1'b1);
          check("w2_result", {cout2, sum2}, ref3);
          @(posedge clk);
          #1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
